// File: rtl/rr_mux_arbiter_if.sv
// Handshake bundle for the round-robin arbitrated mux: N upstream producers,
// one downstream consumer. The slave modport is the arbiter's view.
interface rr_mux_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int CH_W   = $clog2(NUM_CH)
);
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [CH_W-1:0]          out_ch;
  logic                     out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// N-input round-robin arbiter with a registered output word and source index.
// The priority pointer moves to one past the granted channel on every grant.
module rr_mux_arbiter #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input logic             clk,
  input logic             rst,
  rr_mux_arbiter_if.slave bus
);

  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;

  logic [CH_W-1:0]   gnt;
  logic [CH_W-1:0]   cand;
  logic              any;
  logic              found;
  logic              load;
  logic [DATA_W-1:0] sel_data;

  assign any  = |bus.in_valid;
  assign load = ~out_valid_q | bus.out_ready;

  // First requester at or after the pointer, modulo NUM_CH.
  always_comb begin
    gnt   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      cand = CH_W'((32'(ptr_q) + k) % NUM_CH);
      if (!found && bus.in_valid[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
  end

  // Only the granted lane reaches the register; other lanes may carry X.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (CH_W'(i) == gnt) begin
        sel_data = bus.in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    ptr_d        = ptr_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    bus.in_ready = '0;
    if (load && any) begin
      bus.in_ready[gnt] = 1'b1;
      out_valid_d       = 1'b1;
      out_data_d        = sel_data;
      out_ch_d          = gnt;
      ptr_d             = (gnt == CH_W'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- N-input round-robin arbitrated multiplexer. It is the stage that generates the select for the channel mux and registers the selected word.
- Upstream: N independent producers, each with a valid/ready handshake.
- Downstream: one consumer with a valid/ready handshake.
- The grant index drives the mux select internally and is exported alongside the data so the consumer knows the source channel.
- Turns the combinational 2:1 / N:1 mux primitives into a fair, back-pressure-aware sequential stage.

Parameters:
- NUM_CH, 4, number of input channels; legal range is 2 or more.
- DATA_W, 8, width of each channel's data word.
- CH_W, $clog2(NUM_CH), width of the channel index. Derived parameter; do not override.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  NUM_CH  per-channel request; bit i belongs to channel i.
- in_data  input  NUM_CH*DATA_W  packed channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready  output  NUM_CH  per-channel accept. One-hot or zero.
- out_valid  output  1  registered word available.
- out_data  output  DATA_W  registered selected word.
- out_ch  output  CH_W  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high; it is sampled only on the rising clk edge.
- Reset values: out_valid=0, out_data=0, out_ch=0, priority pointer ptr=0. in_ready is therefore all-zero in the cycle after reset unless a load is possible.
- Reset mid-operation: a held, unaccepted word is discarded and no transfer is signalled.
- Load condition: load = ~out_valid | out_ready. The output register is empty, or is being drained this cycle.
- Arbitration (combinational):
  - Scan channels ptr, ptr+1, …, ptr+NUM_CH-1, modulo NUM_CH.
  - gnt = first index with in_valid=1.
  - any = |in_valid.
- in_ready:
  - in_ready[gnt] = load & any.
  - All other bits are 0.
  - in_ready may depend combinationally on in_valid and out_ready; there is no loop because in_valid must not depend on in_ready.
- Transfer on input i = in_valid[i] & in_ready[i]. At most one input transfer per cycle.
- On clk edge, if load & any:
  - out_data <= in_data[gnt]
  - out_ch <= gnt
  - out_valid <= 1
  - ptr <= (gnt+1) mod NUM_CH, wrapping from NUM_CH-1 to 0.
- On clk edge, if load & ~any: out_valid <= 0. out_data, out_ch and ptr hold.
- On clk edge, if ~load (stall: out_valid=1, out_ready=0): all state holds. out_data and out_ch must be stable for the whole stall.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word/cycle sustained when out_ready=1 continuously.
- Fairness:
  - The pointer advances only on a grant.
  - A continuously requesting channel waits at most NUM_CH-1 grants.
  - No channel may be granted twice while another channel requests continuously.
- Simultaneous events: drain and refill in the same cycle (out_valid=1, out_ready=1, any=1) is a back-to-back transfer. No bubble is allowed.
- Single requester: the same channel is granted every cycle. ptr rotates past it but it is still the first found.
- in_data of non-granted channels is ignored. X on those channels must not propagate to the outputs.

Test Plan:
- Reset check: assert rst for 2 cycles with in_valid=4'b1111 and out_ready=1 → out_valid=0, out_data=0, out_ch=0 during reset. First grant after release is ch0.
- Round robin:
  - Stimulus: in_valid=4'b1111 held, in_data={8'h44,8'h33,8'h22,8'h11}, out_ready=1.
  - Required: out_ch sequence 0,1,2,3,0 on consecutive cycles; out_data 11,22,33,44,11; exactly one in_ready bit high per cycle.
- Back-pressure:
  - Stimulus: word from ch2 (in_data=8'hA5) loaded, then out_ready=0 for 5 cycles while ch0 and ch3 request.
  - Required: out_valid=1, out_data=A5 and out_ch=2 are stable, and in_ready=0, for all 5 cycles. When out_ready=1 is restored, ch3 is granted next (ptr=3), then ch0.
- Sparse/wrap:
  - Stimulus: only ch3 requests (in_data ch3=8'h7E) for 3 cycles, then only ch0 (8'h01).
  - Required: out_ch=3 three times, then 0. Also, starting from ptr=3 with in_valid=4'b0101, ch0 is granted before ch2.
- Idle bubble: single ch1 word (8'h5A), then in_valid=0 with out_ready=1 → out_valid=1 for exactly one cycle, then 0. out_data stays 5A after out_valid falls.
- Mid-stall reset: word held with out_ready=0, assert rst for 1 cycle → out_valid=0 next cycle, ptr=0, and the held word is never transferred.
